// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parity encodings, FSM states and width helpers.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_e;

   function automatic int cnt_width(input int clks);
      return $clog2(clks);
   endfunction

   function automatic int idx_width(input int bits);
      return $clog2(bits);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Enabled-tick counter for the UART receiver.
// Load restarts the count; sample fires after a half or full bit period.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic load_i,
   input  logic half_i,
   output logic sample_o
);
   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic          half_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         half_q <= 1'b0;
      end else if (en_i) begin
         if (load_i) begin
            cnt_q  <= '0;
            half_q <= half_i;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign sample_o = (cnt_q == (half_q ? HALF_LAST : FULL_LAST));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch rejection and error flags.
// Received words are held in a valid/ready register with overrun detect.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 CLKIN,
   input  logic                 RESET,
   input  logic                 clock_enable,
   input  logic                 rx,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int IW = idx_width(DATA_BITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic ODD      = (PARITY_MODE == PARITY_ODD);
   localparam logic HAS_PAR  = (PARITY_MODE != PARITY_NONE);
   localparam logic ONE_STOP = (STOP_BITS == 1);

   state_e               state_q;
   logic [1:0]           sync_q;
   logic [IW-1:0]        idx_q;
   logic                 stop_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 perr_out_q;
   logic                 ferr_q;
   logic                 ovr_q;

   logic rs;
   logic sample;
   logic tmr_load;
   logic tmr_half;
   logic stop_last;
   logic deliver;

   assign rs = sync_q[1];

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk_i   (CLKIN),
      .rst_i   (RESET),
      .en_i    (clock_enable),
      .load_i  (tmr_load),
      .half_i  (tmr_half),
      .sample_o(sample)
   );

   // Timer restarts on start detection (half period) and on every sample.
   always_comb begin
      tmr_load = 1'b0;
      tmr_half = 1'b0;
      if (state_q == IDLE) begin
         tmr_load = !rs;
         tmr_half = 1'b1;
      end else begin
         tmr_load = sample;
      end
   end

   assign stop_last = ONE_STOP || stop_q;
   assign deliver   = (state_q == STOP) && sample && rs && stop_last;

   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else if (clock_enable) begin
         sync_q <= {sync_q[0], rx};
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (!rs) state_q <= START;
            end
            START: begin
               if (sample) begin
                  if (rs) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     idx_q   <= '0;
                     perr_q  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (sample) begin
                  shift_q[idx_q] <= rs;
                  if (idx_q == IDX_LAST) begin
                     state_q <= HAS_PAR ? PARITY : STOP;
                     stop_q  <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (sample) begin
                  perr_q  <= (^shift_q) ^ rs ^ ODD;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (sample) begin
                  if (!rs) begin
                     ferr_q  <= 1'b1;
                     state_q <= BREAK;
                  end else if (stop_last) begin
                     state_q <= IDLE;
                  end else begin
                     stop_q <= 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rs) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // A consumed word frees the register for a same-tick delivery.
         if (deliver) begin
            if (!valid_q || ready) begin
               data_q     <= shift_q;
               perr_out_q <= perr_q;
               valid_q    <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, even and odd parity instances.
// Expected words, flags and tick latencies are hand-computed.
module tb_uart_rx_param;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst;
   logic ce;
   logic rx_line;
   logic ready;
   int   sel;

   logic rx_n;
   logic rx_p;

   logic [7:0] d_n, d_e, d_o;
   logic v_n, pe_n, fe_n, ov_n;
   logic v_e, pe_e, fe_e, ov_e;
   logic v_o, pe_o, fe_o, ov_o;

   int n_tests = 0;
   int n_fail  = 0;

   int   tk       = 0;
   int   ready_at = -1;
   int   vrise    = -1;
   int   nferr    = 0;
   int   novr     = 0;
   logic pv_n     = 1'b0;
   logic was_tick = 1'b0;
   logic div3     = 1'b0;
   int   ph       = 0;

   assign rx_n = (sel == 0) ? rx_line : 1'b1;
   assign rx_p = (sel == 1) ? rx_line : 1'b1;

   always #5 clk = ~clk;

   uart_rx_param #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)
   ) dut_n (
      .CLKIN(clk), .RESET(rst), .clock_enable(ce), .rx(rx_n),
      .ready(ready), .data(d_n), .valid(v_n), .parity_err(pe_n),
      .frame_err(fe_n), .overrun(ov_n)
   );

   uart_rx_param #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)
   ) dut_e (
      .CLKIN(clk), .RESET(rst), .clock_enable(ce), .rx(rx_p),
      .ready(ready), .data(d_e), .valid(v_e), .parity_err(pe_e),
      .frame_err(fe_e), .overrun(ov_e)
   );

   uart_rx_param #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)
   ) dut_o (
      .CLKIN(clk), .RESET(rst), .clock_enable(ce), .rx(rx_p),
      .ready(ready), .data(d_o), .valid(v_o), .parity_err(pe_o),
      .frame_err(fe_o), .overrun(ov_o)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; ready is pulsed on the clock numbered ready_at.
   task automatic step();
      ready = (tk + 1 == ready_at);
      @(posedge clk);
      #1;
      tk++;
      was_tick = ce;
      if (v_n && !pv_n) vrise = tk;
      pv_n = v_n;
      if (fe_n) nferr++;
      if (ov_n) novr++;
      if (div3) begin
         ph = (ph + 1) % 3;
         ce = (ph == 0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_bit(input logic b);
      int n;
      rx_line = b;
      n = 0;
      while (n < CPB) begin
         step();
         if (was_tick) n++;
      end
   endtask

   // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
   task automatic send(input logic [7:0] d, input int par, input logic stopb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (par >= 0) send_bit(par[0]);
      send_bit(stopb);
      rx_line = 1'b1;
   endtask

   task automatic consume();
      ready_at = tk + 1;
      step();
      ready_at = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ce = 1'b1; rx_line = 1'b1; ready = 1'b0; sel = 0;
      idle(3);
      check("rst_data", d_n, 8'h00);
      check("rst_valid", v_n, 0);
      check("rst_perr", pe_n, 0);
      check("rst_ferr", fe_n, 0);
      check("rst_ovr", ov_n, 0);
      rst = 1'b0;
      idle(10);

      // 8N1 0xA5: rx sampled low on clock 1, rs low 2 ticks later,
      // FSM sees it at t0=3, valid at t0+8+144 = 155.
      vrise = -1; tk = 0;
      send(8'hA5, -1, 1'b1);
      check("a5_rise", vrise, 155);
      check("a5_data", d_n, 8'hA5);
      check("a5_valid", v_n, 1);
      check("a5_perr", pe_n, 0);
      idle(10);
      check("a5_hold", v_n, 1);
      consume();
      check("a5_consumed", v_n, 0);
      check("a5_data_kept", d_n, 8'hA5);

      // Start glitch of 4 ticks is rejected at the half-bit resample.
      vrise = -1; nferr = 0;
      rx_line = 1'b0;
      idle(4);
      rx_line = 1'b1;
      idle(30);
      check("glitch_valid", vrise, -1);
      check("glitch_ferr", nferr, 0);
      tk = 0;
      send(8'h3C, -1, 1'b1);
      check("3c_rise", vrise, 155);
      check("3c_data", d_n, 8'h3C);
      consume();

      // Bad stop bit then a long break: exactly one frame_err pulse.
      vrise = -1; nferr = 0;
      send(8'h55, -1, 1'b0);
      rx_line = 1'b0;
      idle(200);
      check("brk_ferr", nferr, 1);
      check("brk_valid", vrise, -1);
      rx_line = 1'b1;
      idle(20);
      tk = 0;
      send(8'h81, -1, 1'b1);
      check("81_rise", vrise, 155);
      check("81_data", d_n, 8'h81);
      check("81_ferr", nferr, 1);
      consume();

      // Back-to-back with ready low: second word dropped.
      novr = 0; tk = 0;
      send(8'h11, -1, 1'b1);
      send(8'h22, -1, 1'b1);
      idle(5);
      check("ovr_data", d_n, 8'h11);
      check("ovr_valid", v_n, 1);
      check("ovr_pulses", novr, 1);
      consume();

      // Second frame starts on clock 161, delivered at 161+154 = 315.
      novr = 0; tk = 0; ready_at = 315;
      send(8'h11, -1, 1'b1);
      send(8'h22, -1, 1'b1);
      ready_at = -1;
      idle(5);
      check("rdy_data", d_n, 8'h22);
      check("rdy_valid", v_n, 1);
      check("rdy_ovr", novr, 0);

      // Reset during data bit 3 while a word is still held.
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rx_line = 1'b1;
      idle(8);
      rst = 1'b1;
      idle(3);
      check("mrst_data", d_n, 8'h00);
      check("mrst_valid", v_n, 0);
      check("mrst_perr", pe_n, 0);
      check("mrst_ferr", fe_n, 0);
      check("mrst_ovr", ov_n, 0);
      rst = 1'b0;
      vrise = -1;
      idle(200);
      check("abort_valid", vrise, -1);
      tk = 0;
      send(8'hF0, -1, 1'b1);
      check("f0_rise", vrise, 155);
      check("f0_data", d_n, 8'hF0);
      consume();

      // Enable on clocks 1,4,7,...: tick 155 lands on clock 3*155-2.
      vrise = -1; tk = 0; ph = 0; ce = 1'b1; div3 = 1'b1;
      send(8'hF0, -1, 1'b1);
      div3 = 1'b0; ce = 1'b1;
      check("div3_rise", vrise, 463);
      check("div3_data", d_n, 8'hF0);
      check("div3_valid", v_n, 1);
      consume();

      // 0x03 has even data parity; parity bit 1 breaks even, suits odd.
      sel = 1;
      idle(5);
      send(8'h03, 1, 1'b1);
      idle(5);
      check("pe1_data_e", d_e, 8'h03);
      check("pe1_valid_e", v_e, 1);
      check("pe1_perr_e", pe_e, 1);
      check("pe1_data_o", d_o, 8'h03);
      check("pe1_perr_o", pe_o, 0);
      consume();
      check("pe1_cons_e", v_e, 0);
      send(8'h03, 0, 1'b1);
      idle(5);
      check("pe0_valid_e", v_e, 1);
      check("pe0_perr_e", pe_e, 0);
      check("pe0_valid_o", v_o, 1);
      check("pe0_perr_o", pe_o, 1);
      consume();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
